tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Shares one serial transmitter among NUM_REQ requesters using round-robin order.
- Captures the granted requester's frame and the baud setting into holding registers.
- Drives the transmitter's tf/framesize/framebits/baudrate inputs and tracks its TXI idle flag to detect start and completion.
- Returns a one-cycle done pulse to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FRAME_W, 128, framebits width; 16 bytes max.
- GAP_CYCLES, 2, cycles tf is held low between frames so the transmitter re-initialises (>=2).
- WDOG_CYCLES, 65535, busy-cycle limit; used only when TX_WDOG_EN is defined.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous reset, active-low.
- req  in  NUM_REQ  per-requester request level; held until that requester's done.
- req_framesize  in  NUM_REQ*4  packed frame byte counts; requester i uses [4i+3:4i].
- req_framebits  in  NUM_REQ*FRAME_W  packed frame data.
- baudrate_cfg  in  8  clocks per bit; sampled at grant.
- grant  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle.
- done  out  NUM_REQ  one-cycle pulse on the owner's bit at completion.
- tf  out  1  transmit flag to the transmitter.
- framesize  out  4  latched frame byte count.
- framebits  out  FRAME_W  latched frame data.
- baudrate  out  8  latched baud divisor.
- TXI  in  1  transmitter idle flag: high = idle/finished, low = sending.
- wdog_err  out  1  one-cycle pulse on watchdog abort (only with TX_WDOG_EN).

Behaviour:
- Reset (reset_n=0 at posedge) forces these values; reset mid-frame aborts with no done pulse:
  - state=IDLE, grant=0, done=0, tf=0, framesize=0, framebits=0, baudrate=3, wdog_err=0.
  - Round-robin pointer rr=0; gap counter=0.
- FSM states are IDLE, LOAD, WAIT_START, BUSY, GAP.
- IDLE:
  - Search req starting at index rr, wrapping modulo NUM_REQ; the first set bit wins (index w).
  - Next cycle: grant[w]=1; latch framesize, framebits and baudrate; state=LOAD.
  - baudrate latches as max(baudrate_cfg,3); values 0..2 are clamped to 3.
  - If the latched framesize==0: no transmission. Go to GAP, pulse done[w] on GAP entry, tf stays 0.
- LOAD: tf<=1; state=WAIT_START. Outputs are stable one cycle before tf rises.
- WAIT_START: wait for TXI==0, then state=BUSY.
  - TXI is high before the transmitter starts, so a high TXI here is not completion.
- BUSY: on TXI==1, pulse done[w] for one cycle, set tf<=0, rr<=(w+1) mod NUM_REQ, state=GAP.
- GAP:
  - tf=0, grant=0.
  - Count GAP_CYCLES cycles, then state=IDLE.
  - A new grant is issued no earlier than GAP_CYCLES+1 cycles after done.
- Latched outputs (framesize, framebits, baudrate) hold their values until the next grant.
  - Requester inputs may change freely after the grant cycle.
- If req[w] drops while granted, the frame still completes and done[w] still pulses.
- A requester that holds req after its own done is re-served only after every other pending requester, which guarantees fairness.
- Simultaneous requests resolve by rr order only. No fixed priority.
- done and grant are never asserted for two requesters at once.

Optional Feature:
- Macro TX_WDOG_EN.
- Defined:
  - A 16-bit counter clears on LOAD and increments in WAIT_START and BUSY.
  - On reaching WDOG_CYCLES: tf<=0, wdog_err pulses, done[w] pulses, rr advances, state=GAP.
- Undefined: no counter; wdog_err is tied to 0; the arbiter waits on TXI indefinitely.

Test Plan:
- Single request: reset, then req=4'b0001, framesize=2, framebits[15:0]=16'hA55A, baudrate_cfg=4.
  - grant=0001 one cycle later; tf rises the cycle after that.
  - The model drops TXI, then raises it 40 cycles later → done=0001 for one cycle, tf=0.
  - The next grant comes at least 3 cycles after done.
- Round-robin: req=4'b1011 held continuously.
  - Grant order is 0001, 0010, 1000, 0001.
  - Each grant comes only after the prior done plus the gap.
- Zero-size frame: req=4'b0100 with framesize=0 → grant=0100, tf stays 0, done=0100 within 3 cycles.
- Clamp and latch: baudrate_cfg=1 → baudrate=3.
  - Changing req_framebits after grant leaves framebits unchanged until done.
- Mid-frame reset: reset_n=0 while in BUSY → the next cycle shows tf=0, grant=0, done=0, rr=0.
- Watchdog (TX_WDOG_EN, WDOG_CYCLES=100): TXI held high after tf rises → at cycle 100, wdog_err=1, done pulses, tf=0.
  - Without the macro, tf stays 1 indefinitely.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter -- round-robin arbiter that shares one serial transmitter
// among NUM_REQ requesters.
//
// The winning requester's frame (byte count + data) and the baud divisor are
// captured into holding registers at grant time. The arbiter then raises tf,
// waits for the transmitter's idle flag TXI to fall (started) and rise again
// (finished). It then returns a one-cycle done pulse to the owner. tf is
// held low for GAP_CYCLES cycles between frames so the transmitter can
// re-initialise.
//
// Optional feature: define TX_WDOG_EN to add a busy watchdog. If the frame
// has not finished within WDOG_CYCLES cycles, the frame is aborted, wdog_err
// pulses and done still pulses. Without the macro, wdog_err is tied low and
// the arbiter waits on TXI indefinitely.
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset_n        synchronous reset, active-low
//   req            per-requester request level
//   req_framesize  packed 4-bit byte counts, requester i at [4i+3:4i]
//   req_framebits  packed FRAME_W-bit frame data, requester i at slice i
//   baudrate_cfg   clocks per bit, sampled at grant (clamped to >= 3)
//   grant          one-hot owner of the transmitter, 0 when idle
//   done           one-cycle pulse on the owner's bit at completion
//   tf             transmit flag to the transmitter
//   framesize      latched frame byte count
//   framebits      latched frame data
//   baudrate       latched baud divisor
//   TXI            transmitter idle flag (1 = idle/finished, 0 = sending)
//   wdog_err       one-cycle pulse on watchdog abort
module tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int FRAME_W     = 128,
   parameter int GAP_CYCLES  = 2,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*4-1:0]       req_framesize,
   input  logic [NUM_REQ*FRAME_W-1:0] req_framebits,
   input  logic [7:0]                 baudrate_cfg,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         done,
   output logic                       tf,
   output logic [3:0]                 framesize,
   output logic [FRAME_W-1:0]         framebits,
   output logic [7:0]                 baudrate,
   input  logic                       TXI,
   output logic                       wdog_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, BUSY, GAP} state_t;

   // Out-of-range parameter sets elaborate this empty block.
   if (GAP_CYCLES < 2 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_params
   end

   state_t               state_reg, state_next;
   logic [IDX_W-1:0]     owner_reg, owner_next;
   logic [IDX_W-1:0]     rr_reg, rr_next;
   logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
   logic [NUM_REQ-1:0]   grant_reg, grant_next;
   logic [NUM_REQ-1:0]   done_reg, done_next;
   logic                 tf_reg, tf_next;
   logic [3:0]           framesize_reg, framesize_next;
   logic [FRAME_W-1:0]   framebits_reg, framebits_next;
   logic [7:0]           baudrate_reg, baudrate_next;

   // Per-requester views of the packed frame inputs.
   logic [3:0]           fs_arr [NUM_REQ];
   logic [FRAME_W-1:0]   fb_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign fs_arr[gi] = req_framesize[4*gi +: 4];
      assign fb_arr[gi] = req_framebits[FRAME_W*gi +: FRAME_W];
   end

   // Round-robin search starting at rr_reg.
   // The loop runs downward so the lowest offset from rr is assigned last and wins.
   logic             win_found;
   logic [IDX_W-1:0] win_idx;

   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_reg) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = idx[IDX_W-1:0];
         end
      end
   end

   logic [IDX_W-1:0] rr_after_owner;
   assign rr_after_owner = (int'(owner_reg) == NUM_REQ - 1) ? '0 : owner_reg + 1'b1;

`ifdef TX_WDOG_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
   logic [15:0] wdog_cnt_reg, wdog_cnt_next;
   logic        wdog_err_reg, wdog_err_next;
`endif

   logic finish;

   always_comb begin
      state_next     = state_reg;
      owner_next     = owner_reg;
      rr_next        = rr_reg;
      gap_cnt_next   = gap_cnt_reg;
      grant_next     = grant_reg;
      done_next      = '0;
      tf_next        = tf_reg;
      framesize_next = framesize_reg;
      framebits_next = framebits_reg;
      baudrate_next  = baudrate_reg;
      finish         = 1'b0;
`ifdef TX_WDOG_EN
      wdog_cnt_next  = wdog_cnt_reg;
      wdog_err_next  = 1'b0;
`endif

      case (state_reg)
         IDLE: begin
            if (win_found) begin
               owner_next          = win_idx;
               grant_next          = '0;
               grant_next[win_idx] = 1'b1;
               framesize_next      = fs_arr[win_idx];
               framebits_next      = fb_arr[win_idx];
               baudrate_next       = (baudrate_cfg < 8'd3) ? 8'd3 : baudrate_cfg;
               state_next          = LOAD;
            end
         end
         LOAD: begin
`ifdef TX_WDOG_EN
            wdog_cnt_next = '0;
`endif
            // A zero-length frame completes without touching the transmitter.
            if (framesize_reg == 4'd0) begin
               finish = 1'b1;
            end else begin
               tf_next    = 1'b1;
               state_next = WAIT_START;
            end
         end
         WAIT_START: begin
            // TXI is still high from the previous idle period; only its fall
            // means the transmitter has picked the frame up.
            if (!TXI) state_next = BUSY;
         end
         BUSY: begin
            if (TXI) finish = 1'b1;
         end
         GAP: begin
            if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
            else gap_cnt_next = gap_cnt_reg + 1'b1;
         end
         default: state_next = IDLE;
      endcase

`ifdef TX_WDOG_EN
      if (state_reg == WAIT_START || state_reg == BUSY) begin
         if (wdog_cnt_reg == WDOG_LIMIT && !(state_reg == BUSY && TXI)) begin
            finish        = 1'b1;
            wdog_err_next = 1'b1;
         end else begin
            wdog_cnt_next = wdog_cnt_reg + 16'd1;
         end
      end
`endif

      if (finish) begin
         done_next            = '0;
         done_next[owner_reg] = 1'b1;
         grant_next           = '0;
         tf_next              = 1'b0;
         rr_next              = rr_after_owner;
         gap_cnt_next         = '0;
         state_next           = GAP;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         owner_reg     <= '0;
         rr_reg        <= '0;
         gap_cnt_reg   <= '0;
         grant_reg     <= '0;
         done_reg      <= '0;
         tf_reg        <= 1'b0;
         framesize_reg <= '0;
         framebits_reg <= '0;
         baudrate_reg  <= 8'd3;
`ifdef TX_WDOG_EN
         wdog_cnt_reg  <= '0;
         wdog_err_reg  <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         owner_reg     <= owner_next;
         rr_reg        <= rr_next;
         gap_cnt_reg   <= gap_cnt_next;
         grant_reg     <= grant_next;
         done_reg      <= done_next;
         tf_reg        <= tf_next;
         framesize_reg <= framesize_next;
         framebits_reg <= framebits_next;
         baudrate_reg  <= baudrate_next;
`ifdef TX_WDOG_EN
         wdog_cnt_reg  <= wdog_cnt_next;
         wdog_err_reg  <= wdog_err_next;
`endif
      end
   end

   assign grant     = grant_reg;
   assign done      = done_reg;
   assign tf        = tf_reg;
   assign framesize = framesize_reg;
   assign framebits = framebits_reg;
   assign baudrate  = baudrate_reg;
`ifdef TX_WDOG_EN
   assign wdog_err  = wdog_err_reg;
`else
   assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter (default parameters, watchdog disabled).
// A small transmitter model drives TXI in response to tf. Each expected done
// owner is queued when the request is driven, and it is popped and compared
// by a monitor whenever done pulses.
module tb_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int FRAME_W = 128;
   localparam int GAP     = 2;

   logic                       clk;
   logic                       reset_n;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*4-1:0]       req_framesize;
   logic [NUM_REQ*FRAME_W-1:0] req_framebits;
   logic [7:0]                 baudrate_cfg;
   logic [NUM_REQ-1:0]         grant;
   logic [NUM_REQ-1:0]         done;
   logic                       tf;
   logic [3:0]                 framesize;
   logic [FRAME_W-1:0]         framebits;
   logic [7:0]                 baudrate;
   logic                       TXI;
   logic                       wdog_err;

   tx_arbiter #(
      .NUM_REQ(NUM_REQ), .FRAME_W(FRAME_W), .GAP_CYCLES(GAP), .WDOG_CYCLES(65535)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_framesize(req_framesize),
      .req_framebits(req_framebits), .baudrate_cfg(baudrate_cfg), .grant(grant),
      .done(done), .tf(tf), .framesize(framesize), .framebits(framebits),
      .baudrate(baudrate), .TXI(TXI), .wdog_err(wdog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   logic [NUM_REQ-1:0] exp_q [$];

   bit txi_en = 1'b1;
   int tx_len = 40;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, got);
      end
   endtask

   // Transmitter model: picks the frame up 2 cycles after tf rises, stays busy
   // for tx_len cycles, then goes idle and waits for tf to drop.
   initial begin
      TXI = 1'b1;
      forever begin
         @(negedge clk);
         if (txi_en && tf && TXI) begin
            repeat (2) @(negedge clk);
            TXI = 1'b0;
            repeat (tx_len) @(negedge clk);
            TXI = 1'b1;
            while (tf) @(negedge clk);
         end
      end
   end

   // Scoreboard monitor: every done pulse must match the next queued owner.
   always @(negedge clk) begin
      if (reset_n && done != '0) begin
         if (exp_q.size() == 0) check("done_unexpected", done, '0);
         else check("done_owner", done, exp_q.pop_front());
      end
      if (wdog_err) check("wdog_err_low", wdog_err, 1'b0);
   end

   task automatic set_frame(input int idx, input logic [3:0] fs, input logic [FRAME_W-1:0] fb);
      req_framesize[4*idx +: 4]             = fs;
      req_framebits[FRAME_W*idx +: FRAME_W] = fb;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (grant == '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (grant == '0) check({tag, "_grant_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done == '0 && n < 300);
      if (done == '0) check({tag, "_done_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   logic [NUM_REQ-1:0] rr_order [4];
   logic [FRAME_W-1:0] fb_a;
   int                 done_cyc;
   bit                 saw_done;

   initial begin
      reset_n = 1'b0;
      req = '0;
      req_framesize = '0;
      req_framebits = '0;
      baudrate_cfg = 8'd0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_grant", grant, '0);
      check("rst_done", done, '0);
      check("rst_tf", tf, 1'b0);
      check("rst_framesize", framesize, '0);
      check("rst_framebits", framebits, '0);
      check("rst_baudrate", baudrate, 8'd3);
      check("rst_wdog_err", wdog_err, 1'b0);

      // Single request
      reset_n = 1'b1;
      set_frame(0, 4'd2, 128'hA55A);
      baudrate_cfg = 8'd4;
      req = 4'b0001;
      exp_q.push_back(4'b0001);
      @(negedge clk);
      check("single_grant", grant, 4'b0001);
      check("single_tf_low", tf, 1'b0);
      check("single_framesize", framesize, 4'd2);
      check("single_framebits", framebits, 128'hA55A);
      check("single_baudrate", baudrate, 8'd4);
      @(negedge clk);
      check("single_tf_high", tf, 1'b1);
      wait_done("single");
      check("single_tf_done", tf, 1'b0);
      req = '0;
      repeat (GAP + 2) @(negedge clk);

      // Round-robin with 1011 held continuously, starting from rr=0
      pulse_reset();
      rr_order[0] = 4'b0001; rr_order[1] = 4'b0010;
      rr_order[2] = 4'b1000; rr_order[3] = 4'b0001;
      set_frame(0, 4'd1, 128'h11);
      set_frame(1, 4'd1, 128'h22);
      set_frame(3, 4'd1, 128'h44);
      baudrate_cfg = 8'd8;
      for (int t = 0; t < 4; t++) exp_q.push_back(rr_order[t]);
      req = 4'b1011;
      done_cyc = 0;
      for (int t = 0; t < 4; t++) begin
         wait_grant("rr");
         check("rr_grant", grant, rr_order[t]);
         if (t > 0) check("rr_gap_ge3", (cyc - done_cyc) >= GAP + 1, 1'b1);
         wait_done("rr");
         done_cyc = cyc;
         if (t == 3) req = '0;
      end
      repeat (GAP + 2) @(negedge clk);

      // Zero-size frame: rr=1, only requester 2 asks
      set_frame(2, 4'd0, 128'h33);
      req = 4'b0100;
      exp_q.push_back(4'b0100);
      @(negedge clk);
      check("zero_grant", grant, 4'b0100);
      saw_done = 1'b0;
      for (int k = 0; k < 3 && !saw_done; k++) begin
         @(negedge clk);
         check("zero_tf_low", tf, 1'b0);
         if (done != '0) saw_done = 1'b1;
      end
      check("zero_done_seen", saw_done, 1'b1);
      req = '0;
      repeat (GAP + 2) @(negedge clk);

      // Clamp and latch: rr=3 wraps to requester 0
      fb_a = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      set_frame(0, 4'd5, fb_a);
      baudrate_cfg = 8'd1;
      req = 4'b0001;
      exp_q.push_back(4'b0001);
      @(negedge clk);
      check("clamp_grant", grant, 4'b0001);
      check("clamp_baudrate", baudrate, 8'd3);
      set_frame(0, 4'd9, ~fb_a);
      baudrate_cfg = 8'd200;
      wait_done("clamp");
      check("latch_framebits", framebits, fb_a);
      check("latch_framesize", framesize, 4'd5);
      check("latch_baudrate", baudrate, 8'd3);
      req = '0;
      repeat (GAP + 2) @(negedge clk);

      // Mid-frame reset: requester 1 aborted in BUSY, no done expected
      set_frame(1, 4'd3, 128'h77);
      baudrate_cfg = 8'd10;
      req = 4'b0010;
      @(negedge clk);
      check("abort_grant", grant, 4'b0010);
      for (int n = 0; n < 20 && TXI; n++) @(negedge clk);
      check("abort_txi_low", TXI, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      req = '0;
      @(negedge clk);
      check("abort_tf", tf, 1'b0);
      check("abort_grant0", grant, '0);
      check("abort_done0", done, '0);
      check("abort_baudrate", baudrate, 8'd3);
      reset_n = 1'b1;
      for (int n = 0; n < 100 && !TXI; n++) @(negedge clk);
      check("abort_txi_idle", TXI, 1'b1);
      // rr must be back at 0: with 0011 pending, requester 0 wins
      set_frame(0, 4'd1, 128'h88);
      req = 4'b0011;
      exp_q.push_back(4'b0001);
      @(negedge clk);
      check("abort_rr0_grant", grant, 4'b0001);
      wait_done("abort");
      req = '0;
      repeat (GAP + 2) @(negedge clk);

      // TXI never falls: without the watchdog (or with a long limit) tf holds
      txi_en = 1'b0;
      set_frame(2, 4'd1, 128'h99);
      req = 4'b0100;
      repeat (150) @(negedge clk);
      check("hang_tf_high", tf, 1'b1);
      check("hang_grant", grant, 4'b0100);
      check("hang_done0", done, '0);
      req = '0;
      pulse_reset();
      txi_en = 1'b1;
      @(negedge clk);

      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
